// File: rtl/mul16_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential 16x16 multiply controller.
`timescale 1ns/1ps
interface mul16_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        approx_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic [2:0]  pp_count;

    modport master (
        output in_valid, a, b, approx_en, out_ready,
        input  in_ready, out_valid, c, pp_count
    );

    modport slave (
        input  in_valid, a, b, approx_en, out_ready,
        output in_ready, out_valid, c, pp_count
    );
endinterface

// File: rtl/mul16_seq_ctrl.sv
// Sequential 16x16 unsigned multiply built from one shared 8x8 multiplier,
// issuing only the byte partial products whose high bytes are non-zero.
`timescale 1ns/1ps
module mul16_seq_ctrl #(
    parameter int W_BYTE = 8    // only 8 is supported
) (
    input  logic              clk,
    input  logic              rst_n,
    mul16_seq_ctrl_if.slave   bus,
    output logic              busy
);
    localparam int W_OP  = 2 * W_BYTE;
    localparam int W_ACC = 4 * W_BYTE;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t              state_q, state_d;
    logic [W_BYTE-1:0]   lo_a_q, lo_a_d, hi_a_q, hi_a_d;
    logic [W_BYTE-1:0]   lo_b_q, lo_b_d, hi_b_q, hi_b_d;
    logic [3:0]          mask_q, mask_d;
    logic [W_ACC-1:0]    acc_q, acc_d;
    logic [2:0]          pp_q, pp_d;

    logic                hi_a_nz, hi_b_nz;
    logic [3:0]          new_mask;
    logic [2:0]          new_pp;
    logic [1:0]          sel_idx;
    logic [W_BYTE-1:0]   op_x, op_y;
    logic [W_OP-1:0]     pp_prod;
    logic [W_ACC-1:0]    pp_ext, pp_shifted;

    // Schedule for the operands currently on the bus, used only at accept.
    always_comb begin
        hi_a_nz     = |bus.a[W_OP-1:W_BYTE];
        hi_b_nz     = |bus.b[W_OP-1:W_BYTE];
        new_mask[0] = !(bus.approx_en && hi_a_nz && hi_b_nz);
        new_mask[1] = hi_b_nz;
        new_mask[2] = hi_a_nz;
        new_mask[3] = hi_a_nz && hi_b_nz;
        new_pp      = {2'b00, new_mask[0]} + {2'b00, new_mask[1]}
                    + {2'b00, new_mask[2]} + {2'b00, new_mask[3]};
    end

    // Lowest pending product owns the shared multiplier this cycle.
    always_comb begin
        if (mask_q[0])      sel_idx = 2'd0;
        else if (mask_q[1]) sel_idx = 2'd1;
        else if (mask_q[2]) sel_idx = 2'd2;
        else                sel_idx = 2'd3;

        case (sel_idx)
            2'd0:    begin op_x = lo_a_q; op_y = lo_b_q; end
            2'd1:    begin op_x = lo_a_q; op_y = hi_b_q; end
            2'd2:    begin op_x = hi_a_q; op_y = lo_b_q; end
            default: begin op_x = hi_a_q; op_y = hi_b_q; end
        endcase

        pp_prod = {{W_BYTE{1'b0}}, op_x} * {{W_BYTE{1'b0}}, op_y};
        pp_ext  = {{W_OP{1'b0}}, pp_prod};

        case (sel_idx)
            2'd0:    pp_shifted = pp_ext;
            2'd1,
            2'd2:    pp_shifted = pp_ext << W_BYTE;
            default: pp_shifted = pp_ext << W_OP;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        lo_a_d        = lo_a_q;
        hi_a_d        = hi_a_q;
        lo_b_d        = lo_b_q;
        hi_b_d        = hi_b_q;
        mask_d        = mask_q;
        acc_d         = acc_q;
        pp_d          = pp_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    lo_a_d  = bus.a[W_BYTE-1:0];
                    hi_a_d  = bus.a[W_OP-1:W_BYTE];
                    lo_b_d  = bus.b[W_BYTE-1:0];
                    hi_b_d  = bus.b[W_OP-1:W_BYTE];
                    mask_d  = new_mask;
                    pp_d    = new_pp;
                    acc_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                busy            = 1'b1;
                acc_d           = acc_q + pp_shifted;
                mask_d[sel_idx] = 1'b0;
                if (mask_d == 4'b0000) state_d = DONE;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_a_q  <= '0;
            hi_a_q  <= '0;
            lo_b_q  <= '0;
            hi_b_q  <= '0;
            mask_q  <= '0;
            acc_q   <= '0;
            pp_q    <= '0;
        end else begin
            state_q <= state_d;
            lo_a_q  <= lo_a_d;
            hi_a_q  <= hi_a_d;
            lo_b_q  <= lo_b_d;
            hi_b_q  <= hi_b_d;
            mask_q  <= mask_d;
            acc_q   <= acc_d;
            pp_q    <= pp_d;
        end
    end

    assign bus.c        = acc_q;
    assign bus.pp_count = pp_q;
endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Self-checking bench for mul16_seq_ctrl: directed vectors plus a stalled
// random stream compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mul16_seq_ctrl;
    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   errors;
    int   results;
    logic drv_done;
    logic [34:0] exp_q[$];

    mul16_seq_ctrl_if bus();

    mul16_seq_ctrl #(.W_BYTE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_c(input logic [15:0] av, input logic [15:0] bv, input logic ap);
        logic [31:0] p;
        logic [7:0]  la, lb;
        la = av[7:0];
        lb = bv[7:0];
        p  = 32'(av) * 32'(bv);
        if (ap && av > 16'd255 && bv > 16'd255) p = p - 32'(la) * 32'(lb);
        return p;
    endfunction

    function automatic logic [2:0] model_pp(input logic [15:0] av, input logic [15:0] bv, input logic ap);
        if (av > 16'd255 && bv > 16'd255) return ap ? 3'd3 : 3'd4;
        if (av > 16'd255 || bv > 16'd255) return 3'd2;
        return 3'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: record accepts, compare every presented result in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("in_ready_vs_busy", 32'(bus.in_ready), 32'(!busy));
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back({model_pp(bus.a, bus.b, bus.approx_en), model_c(bus.a, bus.b, bus.approx_en)});
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result actual c=0x%08h required none", bus.c);
                end else begin
                    check("sb_c", bus.c, exp_q[0][31:0]);
                    check("sb_pp_count", 32'(bus.pp_count), 32'(exp_q[0][34:32]));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        results++;
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [15:0] av, input logic [15:0] bv, input logic ap, input int k);
        int n;
        @(posedge clk); #1;
        bus.a = av; bus.b = bv; bus.approx_en = ap; bus.in_valid = 1'b1;
        @(negedge clk);
        check("accept_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(k));
    endtask

    task automatic check_output(input logic [31:0] ec, input logic [2:0] ep);
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("c", bus.c, ec);
        check("pp_count", 32'(bus.pp_count), 32'(ep));
        check("busy_done", 32'(busy), 32'd1);
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("handoff_out_valid", 32'(bus.out_valid), 32'd0);
        check("handoff_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic check_reset_state();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_c", bus.c, 32'd0);
        check("rst_pp_count", 32'(bus.pp_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int cyc;
        checks = 0; errors = 0; results = 0; drv_done = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.approx_en = 1'b0; bus.out_ready = 1'b0;

        check("pin_model_exact", model_c(16'h1234, 16'h5678, 1'b0), 32'h06260060);
        check("pin_model_approx", model_c(16'h1234, 16'h5678, 1'b1), 32'h0625E800);
        check("pin_model_pp", 32'(model_pp(16'h0100, 16'h00FF, 1'b1)), 32'd2);
        check("pin_model_max", model_c(16'hFFFF, 16'hFFFF, 1'b0), 32'hFFFE0001);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_state();

        apply_stimulus(16'h0003, 16'h0005, 1'b0, 1);
        check_output(32'h0000000F, 3'd1);
        handoff();
        apply_stimulus(16'h1234, 16'h5678, 1'b0, 4);
        check_output(32'h06260060, 3'd4);
        handoff();
        apply_stimulus(16'h1234, 16'h5678, 1'b1, 3);
        check_output(32'h0625E800, 3'd3);
        handoff();
        apply_stimulus(16'h0100, 16'h00FF, 1'b0, 2);
        check_output(32'h0000FF00, 3'd2);
        handoff();
        apply_stimulus(16'hFFFF, 16'hFFFF, 1'b0, 4);
        check_output(32'hFFFE0001, 3'd4);

        // Held result must ignore operand churn while the consumer stalls.
        for (int i = 0; i < 3; i++) begin
            bus.a = 16'($urandom); bus.b = 16'($urandom); bus.approx_en = 1'($urandom); bus.in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_c", bus.c, 32'hFFFE0001);
            check("bp_pp_count", 32'(bus.pp_count), 32'd4);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        handoff();

        // Reset lands after two of four products have been accumulated.
        @(posedge clk); #1;
        bus.a = 16'h1234; bus.b = 16'h5678; bus.approx_en = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_state();
        apply_stimulus(16'h0002, 16'h0003, 1'b0, 1);
        check_output(32'h00000006, 3'd1);
        handoff();

        base = results;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    logic [15:0] av, bv;
                    int guard;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    av = 16'($urandom);
                    bv = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) av[15:8] = 8'h00;
                    if ($urandom_range(0, 3) == 0) bv[15:8] = 8'h00;
                    bus.a = av; bus.b = bv; bus.approx_en = 1'($urandom); bus.in_valid = 1'b1;
                    guard = 0;
                    @(negedge clk);
                    while (!bus.in_ready && guard < 100) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (guard >= 100) check("rand_accept_timeout", 32'(guard), 32'd0);
                    @(posedge clk); #1;
                    bus.in_valid = 1'b0;
                end
                drv_done = 1'b1;
            end
            begin
                cyc = 0;
                while (cyc < 60000 && !(drv_done && exp_q.size() == 0 && !bus.out_valid)) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                    cyc++;
                end
                bus.out_ready = 1'b0;
            end
        join
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_result_count", 32'(results - base), 32'd2000);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
